// File: rtl/branch_pkg.sv
// Shared constants for the EX-stage branch controller: funct3 codes, widths, FSM encoding.
package branch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3W  = 3;

  localparam logic [F3W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3W-1:0] F3_BGEU = 3'b111;

  localparam logic [XLEN-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_OPND = 2'd1,
    ST_REDIRECT  = 2'd2
  } br_state_e;

endpackage

// File: rtl/br_target.sv
// Branch/jump target adder with jalr bit0 clearing and word-alignment check on bit1.
module br_target
  import branch_pkg::*;
(
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic            is_jalr_i,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  always_comb begin
    base       = is_jalr_i ? rs1_i : pc_i;
    sum        = base + imm_i;
    target_o   = is_jalr_i ? {sum[XLEN-1:1], 1'b0} : sum;
    misalign_o = target_o[1];
  end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: load-use stall, one-cycle redirect/flush, misalign pulse, perf counters.
module branch_ctrl
  import branch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            br_valid,
  input  logic [F3W-1:0]  br_type,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            breq,
  input  logic            brlt,
  input  logic            brltu,
  input  logic            opnd_ready,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            clr_cnt,
  output logic            stall,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic            misalign_err,
  output logic [XLEN-1:0] br_cnt,
  output logic [XLEN-1:0] taken_cnt
);

  br_state_e       state_q, state_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] br_cnt_q, br_cnt_d;
  logic [XLEN-1:0] taken_cnt_q, taken_cnt_d;

  logic [XLEN-1:0] target_c;
  logic            tgt_misalign_c;
  logic            taken_c;
  logic            cond_c;
  logic            resolve_c;
  logic            redir_c;

  br_target u_target (
    .pc_i      (pc_ex),
    .imm_i     (imm),
    .rs1_i     (rs1_data),
    .is_jalr_i (is_jalr),
    .target_o  (target_c),
    .misalign_o(tgt_misalign_c)
  );

  // Taken decision; jumps override funct3, and funct3 010/011 are neither taken nor counted.
  always_comb begin
    taken_c = 1'b0;
    cond_c  = 1'b0;
    if (is_jal || is_jalr) begin
      taken_c = 1'b1;
    end else begin
      case (br_type)
        F3_BEQ:  begin cond_c = 1'b1; taken_c = breq;   end
        F3_BNE:  begin cond_c = 1'b1; taken_c = !breq;  end
        F3_BLT:  begin cond_c = 1'b1; taken_c = brlt;   end
        F3_BGE:  begin cond_c = 1'b1; taken_c = !brlt;  end
        F3_BLTU: begin cond_c = 1'b1; taken_c = brltu;  end
        F3_BGEU: begin cond_c = 1'b1; taken_c = !brltu; end
        default: ;
      endcase
    end
  end

  // The REDIRECT slot holds a wrong-path instruction, so nothing resolves there.
  always_comb begin
    resolve_c = opnd_ready &&
                ((state_q == ST_IDLE && br_valid) || state_q == ST_WAIT_OPND);
    redir_c   = resolve_c && taken_c && !tgt_misalign_c;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (br_valid) begin
          if (!opnd_ready)  state_d = ST_WAIT_OPND;
          else if (redir_c) state_d = ST_REDIRECT;
        end
      end
      ST_WAIT_OPND: begin
        if (opnd_ready) state_d = redir_c ? ST_REDIRECT : ST_IDLE;
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Stall is combinational so the pipeline freezes in the same cycle the hazard is seen.
  always_comb begin
    stall       = 1'b0;
    pc_redirect = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    case (state_q)
      ST_IDLE:      stall = br_valid && !opnd_ready;
      ST_WAIT_OPND: stall = !opnd_ready;
      ST_REDIRECT: begin
        pc_redirect = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    redirect_pc_d = redir_c ? target_c : redirect_pc_q;
    misalign_d    = resolve_c && taken_c && tgt_misalign_c;
    br_cnt_d      = br_cnt_q;
    taken_cnt_d   = taken_cnt_q;
    if (clr_cnt) begin
      br_cnt_d    = '0;
      taken_cnt_d = '0;
    end else if (resolve_c && cond_c) begin
      if (br_cnt_q != CNT_MAX)              br_cnt_d    = br_cnt_q + XLEN'(1);
      if (taken_c && taken_cnt_q != CNT_MAX) taken_cnt_d = taken_cnt_q + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
      br_cnt_q      <= '0;
      taken_cnt_q   <= '0;
    end else begin
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
      br_cnt_q      <= br_cnt_d;
      taken_cnt_q   <= taken_cnt_d;
    end
  end

  assign redirect_pc  = redirect_pc_q;
  assign misalign_err = misalign_q;
  assign br_cnt       = br_cnt_q;
  assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed-vector bench for branch_ctrl with hand-computed expectations.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_valid = 1'b0;
  logic [2:0]  br_type = 3'b000;
  logic        is_jal = 1'b0;
  logic        is_jalr = 1'b0;
  logic        breq = 1'b0;
  logic        brlt = 1'b0;
  logic        brltu = 1'b0;
  logic        opnd_ready = 1'b1;
  logic [31:0] pc_ex = '0;
  logic [31:0] imm = '0;
  logic [31:0] rs1_data = '0;
  logic        clr_cnt = 1'b0;
  logic        stall;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign_err;
  logic [31:0] br_cnt;
  logic [31:0] taken_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .br_valid    (br_valid),
    .br_type     (br_type),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .breq        (breq),
    .brlt        (brlt),
    .brltu       (brltu),
    .opnd_ready  (opnd_ready),
    .pc_ex       (pc_ex),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .clr_cnt     (clr_cnt),
    .stall       (stall),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .misalign_err(misalign_err),
    .br_cnt      (br_cnt),
    .taken_cnt   (taken_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    br_valid   = 1'b0;
    br_type    = 3'b000;
    is_jal     = 1'b0;
    is_jalr    = 1'b0;
    breq       = 1'b0;
    brlt       = 1'b0;
    brltu      = 1'b0;
    opnd_ready = 1'b1;
    pc_ex      = '0;
    imm        = '0;
    rs1_data   = '0;
    clr_cnt    = 1'b0;
  endtask

  task automatic set_br(input logic [2:0] f3, input logic eq, input logic lt, input logic ltu,
                        input logic [31:0] pc, input logic [31:0] im);
    idle_in();
    br_valid = 1'b1;
    br_type  = f3;
    breq     = eq;
    brlt     = lt;
    brltu    = ltu;
    pc_ex    = pc;
    imm      = im;
  endtask

  task automatic check_redir(input string tag, input logic r, input logic [31:0] tgt);
    check({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(r));
    check({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(r));
    check({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(r));
    check({tag, ".redirect_pc"}, redirect_pc, tgt);
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] b, input logic [31:0] t);
    check({tag, ".br_cnt"}, br_cnt, b);
    check({tag, ".taken_cnt"}, taken_cnt, t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset.stall", 32'(stall), 32'd0);
    check("reset.misalign", 32'(misalign_err), 32'd0);
    check_redir("reset", 1'b0, 32'h0);
    check_cnt("reset", 32'd0, 32'd0);

    // BEQ taken
    set_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20);
    #1 check("beq.stall", 32'(stall), 32'd0);
    tick();
    idle_in();
    check_redir("beq", 1'b1, 32'h120);
    check_cnt("beq", 32'd1, 32'd1);
    tick();
    check_redir("beq.after", 1'b0, 32'h120);

    // BLTU not taken although signed lt is set
    set_br(3'b110, 1'b0, 1'b1, 1'b0, 32'h100, 32'h40);
    tick();
    idle_in();
    check_redir("bltu", 1'b0, 32'h120);
    check_cnt("bltu", 32'd2, 32'd1);

    // BGE taken, negative offset
    set_br(3'b101, 1'b0, 1'b0, 1'b1, 32'h200, 32'hFFFF_FFF8);
    tick();
    idle_in();
    check_redir("bge", 1'b1, 32'h1F8);
    check_cnt("bge", 32'd3, 32'd2);
    tick();

    // Illegal funct3 010: nothing happens
    set_br(3'b010, 1'b1, 1'b1, 1'b1, 32'h100, 32'h10);
    tick();
    idle_in();
    check_redir("f3_010", 1'b0, 32'h1F8);
    check_cnt("f3_010", 32'd3, 32'd2);

    // BNE taken, then a taken BEQ presented during REDIRECT must be ignored
    set_br(3'b001, 1'b0, 1'b0, 1'b0, 32'h300, 32'h10);
    tick();
    set_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h400, 32'h40);
    check_redir("bne", 1'b1, 32'h310);
    tick();
    idle_in();
    check_redir("redir_ignore", 1'b0, 32'h310);
    check_cnt("redir_ignore", 32'd4, 32'd3);

    // jalr: 0x2003+6=0x2009, bit0 cleared -> 0x2008; not counted
    idle_in();
    br_valid = 1'b1; is_jalr = 1'b1; pc_ex = 32'h900; rs1_data = 32'h2003; imm = 32'h6;
    tick();
    idle_in();
    check_redir("jalr", 1'b1, 32'h2008);
    check_cnt("jalr", 32'd4, 32'd3);
    tick();

    // jalr misaligned: 0x2001+1=0x2002 has bit1 set
    br_valid = 1'b1; is_jalr = 1'b1; pc_ex = 32'h900; rs1_data = 32'h2001; imm = 32'h1;
    tick();
    idle_in();
    check("jalr_mis.misalign", 32'(misalign_err), 32'd1);
    check_redir("jalr_mis", 1'b0, 32'h2008);
    tick();
    check("jalr_mis.pulse_end", 32'(misalign_err), 32'd0);
    check_redir("jalr_mis.after", 1'b0, 32'h2008);

    // jal overrides a would-be-taken BNE and is not counted
    set_br(3'b001, 1'b0, 1'b0, 1'b0, 32'h1000, 32'h800);
    is_jal = 1'b1;
    tick();
    idle_in();
    check_redir("jal", 1'b1, 32'h1800);
    check_cnt("jal", 32'd4, 32'd3);
    tick();

    // Load-use: three stall cycles, then resolve a taken BLT
    set_br(3'b100, 1'b0, 1'b1, 1'b0, 32'h500, 32'h100);
    opnd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("stall.c%0d", i), 32'(stall), 32'd1);
      tick();
    end
    opnd_ready = 1'b1;
    #1 check("stall.release", 32'(stall), 32'd0);
    tick();
    idle_in();
    check_redir("stall.redir", 1'b1, 32'h600);
    check_cnt("stall", 32'd5, 32'd4);

    // Reset while in REDIRECT
    tick();
    set_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h700, 32'h8);
    tick();
    idle_in();
    check_redir("rst_redir.pre", 1'b1, 32'h708);
    rst = 1'b1;
    clr_cnt = 1'b0;
    tick();
    rst = 1'b0;
    check_redir("rst_redir", 1'b0, 32'h0);
    check("rst_redir.misalign", 32'(misalign_err), 32'd0);
    check("rst_redir.stall", 32'(stall), 32'd0);
    check_cnt("rst_redir", 32'd0, 32'd0);

    // Reset while in WAIT_OPND abandons the branch
    set_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h700, 32'h8);
    opnd_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_in();
    tick();
    check_redir("rst_wait", 1'b0, 32'h0);
    check_cnt("rst_wait", 32'd0, 32'd0);

    // clr_cnt wins over a concurrent taken branch
    set_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20);
    tick();
    idle_in();
    tick();
    check_cnt("clr.pre", 32'd1, 32'd1);
    set_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h40);
    clr_cnt = 1'b1;
    tick();
    idle_in();
    check_redir("clr", 1'b1, 32'h140);
    check_cnt("clr", 32'd0, 32'd0);
    tick();

    // Saturation at all-ones
    force dut.br_cnt_q = 32'hFFFF_FFFF;
    force dut.taken_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt_q;
    release dut.taken_cnt_q;
    set_br(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h20);
    tick();
    idle_in();
    check_cnt("sat", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    clr_cnt = 1'b1;
    tick();
    idle_in();
    check_cnt("sat.clr", 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
